// File: rtl/program_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding,
// default geometry, and small helper functions for byte packing.
package program_loader_pkg;

  localparam int DEF_MEMORY_DEPTH = 32;
  localparam int DEF_DATA_WIDTH   = 32;

  // Loader sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  // Bytes per instruction word for a given word width
  function automatic int bpw_of(input int data_width);
    return data_width / 8;
  endfunction

  // Width of the byte index within a word (at least one bit)
  function automatic int bidx_width(input int bpw);
    return (bpw > 1) ? $clog2(bpw) : 1;
  endfunction

  // Running checksum update: plain XOR of every payload byte
  function automatic logic [7:0] xor_accum(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-RAM write port of the loader.
// The loader is the "slave" side: it consumes the stream and drives the RAM port.
// The "master" side is the serial receiver / memory environment.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic [7:0]            Byte_In;
  logic                  Byte_Valid;
  logic                  Byte_Ready;
  logic                  Mem_WriteEnable;
  logic [DATA_WIDTH-1:0] Mem_Address;
  logic [DATA_WIDTH-1:0] Mem_WriteData;

  modport slave (
    input  Byte_In,
    input  Byte_Valid,
    output Byte_Ready,
    output Mem_WriteEnable,
    output Mem_Address,
    output Mem_WriteData
  );

  modport master (
    output Byte_In,
    output Byte_Valid,
    input  Byte_Ready,
    input  Mem_WriteEnable,
    input  Mem_Address,
    input  Mem_WriteData
  );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Assembles little-endian bytes into one instruction word and keeps the
// running XOR checksum. The byte index wraps to zero after the last byte
// of a word, so consecutive words need no extra clearing.
module program_loader_byte_packer
  import program_loader_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  load_i,
  input  logic [7:0]            byte_i,
  output logic [DATA_WIDTH-1:0] word_o,
  output logic                  last_byte_o,
  output logic [7:0]            xor_o
);

  localparam int BPW = bpw_of(DATA_WIDTH);
  localparam int BIW = bidx_width(BPW);

  logic [BPW-1:0][7:0] word_q;
  logic [BPW-1:0][7:0] word_d;
  logic [BIW-1:0]      bidx_q;
  logic [BIW-1:0]      bidx_d;
  logic [7:0]          xor_q;
  logic [7:0]          xor_d;

  assign last_byte_o = (bidx_q == BIW'(BPW - 1));
  // word_o already contains the byte accepted this cycle, so the top can
  // capture a complete word on the same edge the last byte arrives.
  assign word_o      = word_d;
  assign xor_o       = xor_q;

  // Insert the accepted byte, advance the byte index and fold the checksum
  always_comb begin
    word_d = word_q;
    bidx_d = bidx_q;
    xor_d  = xor_q;
    if (clear_i) begin
      word_d = '0;
      bidx_d = '0;
      xor_d  = 8'h00;
    end else if (load_i) begin
      word_d[bidx_q] = byte_i;
      xor_d          = xor_accum(xor_q, byte_i);
      if (last_byte_o) begin
        bidx_d = '0;
      end else begin
        bidx_d = bidx_q + BIW'(1);
      end
    end else begin
      word_d = word_q;
      bidx_d = bidx_q;
      xor_d  = xor_q;
    end
  end

  // Packer state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      bidx_q <= '0;
      xor_q  <= 8'h00;
    end else begin
      word_q <= word_d;
      bidx_q <= bidx_d;
      xor_q  <= xor_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: fills instruction RAM from a byte stream,
// verifies a trailing XOR checksum and releases the core only after a
// successful load. All outputs are registered from the next state.
module program_loader
  import program_loader_pkg::*;
#(
  parameter  int MEMORY_DEPTH = DEF_MEMORY_DEPTH,
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  localparam int CW           = $clog2(MEMORY_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Start,
  input  logic [CW-1:0]      Load_Words,
  program_loader_if.slave    bus,
  output logic               Cpu_Hold,
  output logic               Done,
  output logic               Error
);

  state_e                state_q;
  state_e                state_d;
  logic [CW-1:0]         idx_q;
  logic [CW-1:0]         idx_d;
  logic [CW-1:0]         words_q;
  logic [CW-1:0]         words_d;

  logic                  byte_ready_q;
  logic                  byte_ready_d;
  logic                  we_q;
  logic                  we_d;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;
  logic                  cpu_hold_q;
  logic                  cpu_hold_d;
  logic                  done_q;
  logic                  done_d;
  logic                  error_q;
  logic                  error_d;

  logic                  pk_clear;
  logic                  pk_load;
  logic [DATA_WIDTH-1:0] pk_word;
  logic                  pk_last;
  logic [7:0]            pk_xor;
  logic                  accept;
  logic                  lw_bad;

  program_loader_byte_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (pk_clear),
    .load_i      (pk_load),
    .byte_i      (bus.Byte_In),
    .word_o      (pk_word),
    .last_byte_o (pk_last),
    .xor_o       (pk_xor)
  );

  // A byte moves only when the stream offers it and we advertise readiness
  assign accept = bus.Byte_Valid && byte_ready_q;
  assign lw_bad = (Load_Words == '0) || (Load_Words > CW'(MEMORY_DEPTH));

  // Next-state logic and packer control
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    words_d  = words_q;
    pk_clear = 1'b0;
    pk_load  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (Start) begin
          pk_clear = 1'b1;
          idx_d    = '0;
          words_d  = Load_Words;
          if (lw_bad) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_RECV;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_RECV: begin
        if (accept) begin
          pk_load = 1'b1;
          if (pk_last) begin
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RECV;
          end
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_WRITE: begin
        if (idx_q == (words_q - CW'(1))) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_RECV;
          idx_d   = idx_q + CW'(1);
        end
      end
      ST_CHECK: begin
        if (accept) begin
          if (bus.Byte_In == pk_xor) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values decoded from the next state so they register with it
  always_comb begin
    byte_ready_d = (state_d == ST_RECV) || (state_d == ST_CHECK);
    we_d         = (state_d == ST_WRITE);
    cpu_hold_d   = (state_d != ST_DONE);
    done_d       = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERROR);
    if (we_d) begin
      addr_d = DATA_WIDTH'(idx_d) << 2'd2;
      data_d = pk_word;
    end else begin
      addr_d = addr_q;
      data_d = data_q;
    end
  end

  // FSM state and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      words_q <= words_d;
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_ready_q <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      byte_ready_q <= byte_ready_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      cpu_hold_q   <= cpu_hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.Byte_Ready      = byte_ready_q;
  assign bus.Mem_WriteEnable = we_q;
  assign bus.Mem_Address     = addr_q;
  assign bus.Mem_WriteData   = data_q;
  assign Cpu_Hold            = cpu_hold_q;
  assign Done                = done_q;
  assign Error               = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a table of whole-load vectors plus
// hand-written sequences for stalls, ignored Start, a full-depth load and
// reset in the middle of a load.
module tb_program_loader;

  localparam int MD = 32;
  localparam int DW = 32;
  localparam int CW = $clog2(MD) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          Start;
  logic [CW-1:0] Load_Words;
  logic          Cpu_Hold;
  logic          Done;
  logic          Error;

  program_loader_if #(.DATA_WIDTH(DW)) ifc ();

  program_loader #(
    .MEMORY_DEPTH (MD),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .Load_Words (Load_Words),
    .bus        (ifc.slave),
    .Cpu_Hold   (Cpu_Hold),
    .Done       (Done),
    .Error      (Error)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] exp_data[$];
  logic [7:0]  tx_q[$];

  // Record every RAM write strobe, sampled mid-cycle
  always @(negedge clk) begin
    if (ifc.Mem_WriteEnable === 1'b1) begin
      wr_addr.push_back(ifc.Mem_Address);
      wr_data.push_back(ifc.Mem_WriteData);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic pulse_start(input int lw);
    @(negedge clk);
    Start      = 1'b1;
    Load_Words = CW'(lw);
    @(negedge clk);
    Start      = 1'b0;
    check("start_hold", {31'd0, Cpu_Hold}, 32'd1);
    check("start_done_low", {31'd0, Done}, 32'd0);
  endtask

  // Offer tx_q byte by byte; optional random stalls and one Start pulse
  task automatic send_bytes(input bit stall, input int start_at, input int budget);
    int i = 0;
    int cyc = 0;
    bit fired = 1'b0;
    bit v;
    while (i < tx_q.size() && cyc < budget) begin
      @(negedge clk);
      cyc++;
      v = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!fired && start_at >= 0 && i == start_at) begin
        Start      = 1'b1;
        Load_Words = CW'(5);
        fired      = 1'b1;
      end else begin
        Start = 1'b0;
      end
      ifc.Byte_Valid = v;
      ifc.Byte_In    = v ? tx_q[i] : 8'hEE;
      if (v && ifc.Byte_Ready) i++;
    end
    @(negedge clk);
    ifc.Byte_Valid = 1'b0;
    Start          = 1'b0;
    check("send_complete", i, tx_q.size());
  endtask

  task automatic wait_end(input string name);
    int c = 0;
    while (!(Done || Error) && c < 40) begin
      @(negedge clk);
      c++;
    end
    check(name, {31'd0, (Done || Error)}, 32'd1);
  endtask

  // Offer bytes in a non-receiving state: none may be accepted
  task automatic check_no_accept(input string name);
    int seen = 0;
    repeat (3) begin
      @(negedge clk);
      ifc.Byte_Valid = 1'b1;
      ifc.Byte_In    = 8'h5A;
      if (ifc.Byte_Ready) seen++;
    end
    @(negedge clk);
    ifc.Byte_Valid = 1'b0;
    check(name, seen, 0);
  endtask

  task automatic check_writes(input string name);
    check($sformatf("%s_nwr", name), wr_addr.size(), exp_data.size());
    for (int k = 0; k < exp_data.size() && k < wr_addr.size(); k++) begin
      check($sformatf("%s_addr%0d", name, k), wr_addr[k], 32'(k * 4));
      check($sformatf("%s_data%0d", name, k), wr_data[k], exp_data[k]);
    end
  endtask

  task automatic clear_logs();
    wr_addr.delete();
    wr_data.delete();
    exp_data.delete();
    tx_q.delete();
  endtask

  task automatic load_case2(input logic [7:0] csum);
    logic [63:0] b = 64'h0000000C_20080013;
    for (int k = 0; k < 8; k++) tx_q.push_back(b[8*k +: 8]);
    tx_q.push_back(csum);
  endtask

  typedef struct {
    int          lw;
    int          nbytes;
    logic [63:0] bytes;
    logic [7:0]  csum;
    logic        exp_done;
    logic        exp_err;
    int          nwr;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [63:0] bytes;
    logic [7:0]  fb;
    logic [7:0]  fx;
    logic [31:0] fw;
    int          seen;

    vecs[0] = '{2, 8, 64'h0000000C_20080013, 8'h37, 1'b1, 1'b0, 2, 32'h20080013, 32'h0000000C};
    vecs[1] = '{2, 8, 64'h0000000C_20080013, 8'h36, 1'b0, 1'b1, 2, 32'h20080013, 32'h0000000C};
    vecs[2] = '{0, 0, 64'h0, 8'h00, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vecs[3] = '{33, 0, 64'h0, 8'h00, 1'b0, 1'b1, 0, 32'h0, 32'h0};
    vecs[4] = '{1, 4, 64'h00000000_0FF055AA, 8'h00, 1'b1, 1'b0, 1, 32'h0FF055AA, 32'h0};
    vecs[5] = '{2, 8, 64'h40302010_04030201, 8'h44, 1'b1, 1'b0, 2, 32'h04030201, 32'h40302010};

    reset          = 1'b1;
    Start          = 1'b0;
    Load_Words     = '0;
    ifc.Byte_Valid = 1'b0;
    ifc.Byte_In    = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset / idle: offered bytes never accepted, core held
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      ifc.Byte_Valid = 1'b1;
      ifc.Byte_In    = 8'hA5;
      if (ifc.Byte_Ready) seen++;
    end
    @(negedge clk);
    ifc.Byte_Valid = 1'b0;
    check("rst_ready_seen", seen, 0);
    check("rst_hold", {31'd0, Cpu_Hold}, 32'd1);
    check("rst_we", {31'd0, ifc.Mem_WriteEnable}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_error", {31'd0, Error}, 32'd0);
    check("rst_addr", ifc.Mem_Address, 32'd0);
    check("rst_data", ifc.Mem_WriteData, 32'd0);
    check("rst_nwr", wr_addr.size(), 0);

    // Table-driven whole loads
    for (int v = 0; v < 6; v++) begin
      clear_logs();
      bytes = vecs[v].bytes;
      for (int b = 0; b < vecs[v].nbytes; b++) tx_q.push_back(bytes[8*b +: 8]);
      if (vecs[v].nbytes > 0) tx_q.push_back(vecs[v].csum);
      if (vecs[v].nwr > 0) exp_data.push_back(vecs[v].w0);
      if (vecs[v].nwr > 1) exp_data.push_back(vecs[v].w1);
      pulse_start(vecs[v].lw);
      if (tx_q.size() > 0) send_bytes(1'b0, -1, 200);
      wait_end($sformatf("vec%0d_end", v));
      check($sformatf("vec%0d_done", v), {31'd0, Done}, {31'd0, vecs[v].exp_done});
      check($sformatf("vec%0d_error", v), {31'd0, Error}, {31'd0, vecs[v].exp_err});
      check($sformatf("vec%0d_hold", v), {31'd0, Cpu_Hold}, {31'd0, ~vecs[v].exp_done});
      check_no_accept($sformatf("vec%0d_noacc", v));
      check_writes($sformatf("vec%0d", v));
    end

    // Random stalls with a Start pulse in the middle of the stream
    clear_logs();
    load_case2(8'h37);
    exp_data.push_back(32'h20080013);
    exp_data.push_back(32'h0000000C);
    pulse_start(2);
    send_bytes(1'b1, 3, 400);
    wait_end("stall_end");
    check("stall_done", {31'd0, Done}, 32'd1);
    check("stall_hold", {31'd0, Cpu_Hold}, 32'd0);
    check_writes("stall");

    // Full-depth load: 32 words, last write at 0x7C
    clear_logs();
    fx = 8'h00;
    for (int w = 0; w < MD; w++) begin
      fw = '0;
      for (int k = 0; k < 4; k++) begin
        fb = 8'((w * 4 + k) * 7 + 3);
        tx_q.push_back(fb);
        fx = fx ^ fb;
        fw = fw | (32'(fb) << (8 * k));
      end
      exp_data.push_back(fw);
    end
    tx_q.push_back(fx);
    pulse_start(MD);
    send_bytes(1'b0, -1, 1000);
    wait_end("full_end");
    check("full_done", {31'd0, Done}, 32'd1);
    check_writes("full");
    if (wr_addr.size() > 0) check("full_last_addr", wr_addr[wr_addr.size() - 1], 32'h0000007C);

    // Reset after the fifth byte: only word 0 reaches memory
    clear_logs();
    load_case2(8'h37);
    while (tx_q.size() > 5) void'(tx_q.pop_back());
    exp_data.push_back(32'h20080013);
    pulse_start(2);
    send_bytes(1'b0, -1, 100);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("mrst_hold", {31'd0, Cpu_Hold}, 32'd1);
    check("mrst_ready", {31'd0, ifc.Byte_Ready}, 32'd0);
    check("mrst_done", {31'd0, Done}, 32'd0);
    check("mrst_error", {31'd0, Error}, 32'd0);
    check_no_accept("mrst_noacc");
    check_writes("mrst");

    // Clean reload after the aborted one
    clear_logs();
    load_case2(8'h37);
    exp_data.push_back(32'h20080013);
    exp_data.push_back(32'h0000000C);
    pulse_start(2);
    send_bytes(1'b0, -1, 200);
    wait_end("reload_end");
    check("reload_done", {31'd0, Done}, 32'd1);
    check("reload_hold", {31'd0, Cpu_Hold}, 32'd0);
    check_writes("reload");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
